// File: rtl/spi_master_txn_scheduler.sv
// spi_master_txn_scheduler: round-robin arbiter in front of one SPI master. Each grant runs
// CS assert, setup delay, a full-duplex MSB-first shift, hold delay and CS deassert, then a
// one-cycle CS-high gap before the next arbitration.
module spi_master_txn_scheduler #(
  parameter  int unsigned NUM_REQ      = 4,
  parameter  int unsigned NO_OF_SLAVES = 4,
  parameter  int unsigned DATA_WIDTH   = 8,
  parameter  int unsigned DIV_W        = 8,
  localparam int unsigned SelW         = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1
) (
  input  logic                         pclk,
  input  logic                         areset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*SelW-1:0]      req_cs_sel,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_tx_data,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done,
  output logic [DATA_WIDTH-1:0]        rx_data,
  output logic                         busy,
  input  logic                         cfg_cpol,
  input  logic                         cfg_cpha,
  input  logic [DIV_W-1:0]             cfg_baud_div,
  input  logic [DIV_W-1:0]             cfg_c2t_delay,
  input  logic [DIV_W-1:0]             cfg_t2c_delay,
  output logic                         sclk,
  output logic [NO_OF_SLAVES-1:0]      cs_n,
  output logic                         mosi,
  input  logic                         miso
);

  localparam int unsigned IdxW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned EdgeW = $clog2(2 * DATA_WIDTH);
  localparam logic [EdgeW-1:0] LastEdge = EdgeW'(2 * DATA_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

  state_e                  state_q, state_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
  logic [NO_OF_SLAVES-1:0] cs_n_q, cs_n_d;
  logic                    sclk_q, sclk_d;
  logic                    mosi_q, mosi_d;
  logic [IdxW-1:0]         ptr_q, ptr_d;
  logic [IdxW-1:0]         owner_q, owner_d;
  logic [DIV_W-1:0]        cnt_q, cnt_d;
  logic [EdgeW-1:0]        edge_q, edge_d;
  logic [DATA_WIDTH-1:0]   tx_sr_q, tx_sr_d;
  logic [DATA_WIDTH-1:0]   rx_sr_q, rx_sr_d;
  logic                    cpha_q, cpha_d;
  logic [DIV_W-1:0]        baud_q, baud_d;
  logic [DIV_W-1:0]        t2c_q, t2c_d;

  logic [SelW-1:0]         sel_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0]   tx_arr  [NUM_REQ];
  logic                    pick_valid;
  logic [IdxW-1:0]         pick_idx;
  logic [31:0]             cand;
  logic                    do_edge;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign sel_arr[g] = req_cs_sel[g*SelW +: SelW];
    assign tx_arr[g]  = req_tx_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Out-of-range selects leave every chip select high.
  function automatic logic [NO_OF_SLAVES-1:0] cs_decode(input logic [SelW-1:0] sel);
    cs_decode = '1;
    for (int unsigned s = 0; s < NO_OF_SLAVES; s++) begin
      if (32'(sel) == s) cs_decode[s] = 1'b0;
    end
  endfunction

  // Round-robin pick: first set request at or after the pointer, wrapping.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(ptr_q) + k) % NUM_REQ;
      if (!pick_valid && req[cand[IdxW-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[IdxW-1:0];
      end
    end
  end

  // Transfer sequencer next-state and registered outputs.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    done_d    = '0;
    rx_data_d = rx_data_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    edge_d    = edge_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    cpha_d    = cpha_q;
    baud_d    = baud_q;
    t2c_d     = t2c_q;
    do_edge   = 1'b0;

    unique case (state_q)
      StIdle: begin
        sclk_d = cfg_cpol;
        if (pick_valid) begin
          state_d          = StSetup;
          grant_d          = '0;
          grant_d[pick_idx] = 1'b1;
          owner_d          = pick_idx;
          cpha_d           = cfg_cpha;
          baud_d           = cfg_baud_div;
          t2c_d            = cfg_t2c_delay;
          cnt_d            = cfg_c2t_delay;
          edge_d           = '0;
          rx_sr_d          = '0;
          cs_n_d           = cs_decode(sel_arr[pick_idx]);
          // CPHA=0 needs the MSB on the wire before the first (sampling) edge.
          if (!cfg_cpha) begin
            mosi_d  = tx_arr[pick_idx][DATA_WIDTH-1];
            tx_sr_d = tx_arr[pick_idx] << 1;
          end else begin
            mosi_d  = 1'b0;
            tx_sr_d = tx_arr[pick_idx];
          end
        end
      end
      StSetup: begin
        // The setup window ends with the first SCLK edge.
        if (cnt_q == '0) begin
          do_edge = 1'b1;
          cnt_d   = baud_q;
          state_d = StShift;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StShift: begin
        if (cnt_q == '0) begin
          do_edge = 1'b1;
          if (edge_q == LastEdge) begin
            state_d = StHold;
            cnt_d   = t2c_q;
          end else begin
            cnt_d = baud_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          state_d   = StGap;
          cs_n_d    = '1;
          done_d    = grant_q;
          rx_data_d = rx_sr_q;
          grant_d   = '0;
          mosi_d    = 1'b0;
          ptr_d     = (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + IdxW'(1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (do_edge) begin
      sclk_d = ~sclk_q;
      edge_d = edge_q + 1'b1;
      // Even edges are leading; CPHA decides whether a given edge launches or samples.
      if (edge_q[0] ^ cpha_q) begin
        mosi_d  = tx_sr_q[DATA_WIDTH-1];
        tx_sr_d = tx_sr_q << 1;
      end else begin
        rx_sr_d = (rx_sr_q << 1) | DATA_WIDTH'(miso);
      end
    end
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      done_q    <= '0;
      rx_data_q <= '0;
      cs_n_q    <= '1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      edge_q    <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      cpha_q    <= 1'b0;
      baud_q    <= '0;
      t2c_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      rx_data_q <= rx_data_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      cpha_q    <= cpha_d;
      baud_q    <= baud_d;
      t2c_q     <= t2c_d;
    end
  end

  assign grant   = grant_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign busy    = (state_q != StIdle);
  assign sclk    = sclk_q;
  assign cs_n    = cs_n_q;
  assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master_txn_scheduler.sv
// Self-checking bench for spi_master_txn_scheduler: per-scenario tasks with a scoreboard of
// expected (owner, rx word) pairs pushed at stimulus time and popped on each done pulse.
module tb_spi_master_txn_scheduler;

  localparam int unsigned NReq = 4;
  localparam int unsigned NSlv = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned DivW = 8;
  localparam int unsigned SelW = 2;

  logic                 pclk = 1'b0;
  logic                 areset = 1'b1;
  logic [NReq-1:0]      req;
  logic [NReq*SelW-1:0] req_cs_sel;
  logic [NReq*DW-1:0]   req_tx_data;
  logic [NReq-1:0]      grant;
  logic [NReq-1:0]      done;
  logic [DW-1:0]        rx_data;
  logic                 busy;
  logic                 cfg_cpol, cfg_cpha;
  logic [DivW-1:0]      cfg_baud_div, cfg_c2t_delay, cfg_t2c_delay;
  logic                 sclk, mosi, miso;
  logic [NSlv-1:0]      cs_n;
  logic                 loop_en, miso_val;

  assign miso = loop_en ? mosi : miso_val;

  always #5 pclk = ~pclk;

  int cycle = 0;
  always @(posedge pclk) cycle <= cycle + 1;

  spi_master_txn_scheduler #(
    .NUM_REQ     (NReq),
    .NO_OF_SLAVES(NSlv),
    .DATA_WIDTH  (DW),
    .DIV_W       (DivW)
  ) dut (
    .pclk         (pclk),
    .areset       (areset),
    .req          (req),
    .req_cs_sel   (req_cs_sel),
    .req_tx_data  (req_tx_data),
    .grant        (grant),
    .done         (done),
    .rx_data      (rx_data),
    .busy         (busy),
    .cfg_cpol     (cfg_cpol),
    .cfg_cpha     (cfg_cpha),
    .cfg_baud_div (cfg_baud_div),
    .cfg_c2t_delay(cfg_c2t_delay),
    .cfg_t2c_delay(cfg_t2c_delay),
    .sclk         (sclk),
    .cs_n         (cs_n),
    .mosi         (mosi),
    .miso         (miso)
  );

  typedef struct packed {
    logic [NReq-1:0] owner;
    logic [DW-1:0]   rx;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  // Observations of the most recent transfer.
  int              m_start, m_first_edge, m_last_edge, m_done_cyc;
  int              m_toggles, m_min_gap, m_max_gap, m_mosi_bad, m_inv_bad;
  logic [NSlv-1:0] m_cs;
  logic [NReq-1:0] m_grant, m_done;
  logic [DW-1:0]   m_rx, m_rise;
  bit              m_timeout;

  // Watch one transfer until done or budget; optionally drop req / perturb inputs after grant.
  task automatic run_xfer(input int budget, input bit drop_req, input bit mutate);
    logic p_sclk, p_mosi;
    logic [NReq-1:0] p_grant;
    int gap;
    m_start = -1; m_first_edge = -1; m_last_edge = -1; m_done_cyc = -1;
    m_toggles = 0; m_min_gap = 1 << 30; m_max_gap = 0; m_mosi_bad = 0; m_inv_bad = 0;
    m_cs = '1; m_grant = '0; m_done = '0; m_rx = '0; m_rise = '0; m_timeout = 1'b1;
    p_sclk = sclk; p_mosi = mosi; p_grant = grant;
    for (int i = 0; i < budget; i++) begin
      @(negedge pclk);
      if ($countones(grant) > 1 || $countones(~cs_n) > 1) m_inv_bad++;
      if (m_start < 0 && grant != '0) begin
        m_start = cycle;
        m_grant = grant;
        m_cs    = cs_n;
        if (drop_req) req = '0;
        if (mutate) begin
          cfg_baud_div = 8'd7;
          req_tx_data  = ~req_tx_data;
        end
      end
      if (m_start >= 0 && sclk != p_sclk) begin
        m_toggles++;
        if (m_toggles == 1) m_first_edge = cycle;
        else begin
          gap = cycle - m_last_edge;
          if (gap < m_min_gap) m_min_gap = gap;
          if (gap > m_max_gap) m_max_gap = gap;
        end
        m_last_edge = cycle;
        if (sclk) m_rise = {m_rise[DW-2:0], mosi};
      end
      if (p_grant != '0 && grant != '0 && mosi != p_mosi && !(p_sclk && !sclk)) m_mosi_bad++;
      p_sclk = sclk; p_mosi = mosi; p_grant = grant;
      if (done != '0) begin
        m_done = done; m_rx = rx_data; m_done_cyc = cycle; m_timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    req = '0; req_cs_sel = '0; req_tx_data = '0;
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_baud_div = 8'd1;
    cfg_c2t_delay = '0; cfg_t2c_delay = '0; loop_en = 1'b1; miso_val = 1'b0;
    #1 areset = 1'b0;
    repeat (3) @(negedge pclk);
    vectors++; if (grant !== 4'h0) begin miscompares++; $display("FAIL reset_grant: got %b want 0000", grant); end
    vectors++; if (done !== 4'h0) begin miscompares++; $display("FAIL reset_done: got %b want 0000", done); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx: got %h want 00", rx_data); end
    vectors++; if (cs_n !== 4'hF) begin miscompares++; $display("FAIL reset_cs_n: got %b want 1111", cs_n); end
    vectors++; if (sclk !== 1'b0 || mosi !== 1'b0) begin miscompares++; $display("FAIL reset_sclk_mosi: got %b%b want 00", sclk, mosi); end
    areset = 1'b1;
    repeat (2) @(negedge pclk);
  endtask

  task automatic test_mode0();
    exp_t e;
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_baud_div = 8'd1; loop_en = 1'b1;
    req_cs_sel[1:0] = 2'd2; req_tx_data[7:0] = 8'hA5;
    sb.push_back('{owner: 4'b0001, rx: 8'hA5});
    req = 4'b0001;
    run_xfer(200, 1'b1, 1'b0);
    vectors++; if (m_timeout) begin miscompares++; $display("FAIL m0_timeout: got timeout want done"); end
    vectors++; if (m_cs !== 4'b1011) begin miscompares++; $display("FAIL m0_cs_n: got %b want 1011", m_cs); end
    vectors++; if (m_toggles != 16) begin miscompares++; $display("FAIL m0_toggles: got %0d want 16", m_toggles); end
    vectors++; if (m_min_gap != 2 || m_max_gap != 2) begin miscompares++; $display("FAIL m0_halfperiod: got %0d..%0d want 2", m_min_gap, m_max_gap); end
    vectors++; if (m_rise !== 8'hA5) begin miscompares++; $display("FAIL m0_mosi_bits: got %h want a5", m_rise); end
    if (sb.size() == 0) begin vectors++; miscompares++; $display("FAIL m0_sb: got empty want entry"); end
    else begin
      e = sb.pop_front();
      vectors++; if (m_done !== e.owner) begin miscompares++; $display("FAIL m0_done: got %b want %b", m_done, e.owner); end
      vectors++; if (m_rx !== e.rx) begin miscompares++; $display("FAIL m0_rx: got %h want %h", m_rx, e.rx); end
    end
    vectors++; if (cs_n !== 4'hF || grant !== 4'h0) begin miscompares++; $display("FAIL m0_release: got cs %b grant %b want 1111 0000", cs_n, grant); end
  endtask

  task automatic test_mode3();
    exp_t e;
    cfg_cpol = 1'b1; cfg_cpha = 1'b1; loop_en = 1'b0; miso_val = 1'b1;
    req_cs_sel[3:2] = 2'd1; req_tx_data[15:8] = 8'h3C;
    repeat (3) @(negedge pclk);
    vectors++; if (sclk !== 1'b1) begin miscompares++; $display("FAIL m3_idle_sclk: got %b want 1", sclk); end
    sb.push_back('{owner: 4'b0010, rx: 8'hFF});
    req = 4'b0010;
    run_xfer(200, 1'b1, 1'b0);
    vectors++; if (m_cs !== 4'b1101) begin miscompares++; $display("FAIL m3_cs_n: got %b want 1101", m_cs); end
    vectors++; if (m_toggles != 16) begin miscompares++; $display("FAIL m3_toggles: got %0d want 16", m_toggles); end
    vectors++; if (m_rise !== 8'h3C) begin miscompares++; $display("FAIL m3_mosi_bits: got %h want 3c", m_rise); end
    vectors++; if (m_mosi_bad != 0) begin miscompares++; $display("FAIL m3_mosi_edge: got %0d bad changes want 0", m_mosi_bad); end
    if (sb.size() == 0) begin vectors++; miscompares++; $display("FAIL m3_sb: got empty want entry"); end
    else begin
      e = sb.pop_front();
      vectors++; if (m_done !== e.owner) begin miscompares++; $display("FAIL m3_done: got %b want %b", m_done, e.owner); end
      vectors++; if (m_rx !== e.rx) begin miscompares++; $display("FAIL m3_rx: got %h want %h", m_rx, e.rx); end
    end
    vectors++; if (sclk !== 1'b1) begin miscompares++; $display("FAIL m3_rest_sclk: got %b want 1", sclk); end
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; loop_en = 1'b1;
    repeat (2) @(negedge pclk);
  endtask

  task automatic test_round_robin();
    exp_t e;
    int order [5] = '{0, 1, 2, 3, 0};
    int prev_done;
    logic [NReq-1:0] eg;
    logic [NSlv-1:0] ecs;
    areset = 1'b0;
    @(negedge pclk);
    areset = 1'b1;
    cfg_baud_div = 8'd0;
    for (int k = 0; k < 4; k++) begin
      req_cs_sel[2*k +: 2] = 2'(k);
      req_tx_data[8*k +: 8] = 8'(8'h11 * (k + 1));
    end
    for (int k = 0; k < 5; k++) begin
      sb.push_back('{owner: 4'(1 << order[k]), rx: 8'(8'h11 * (order[k] + 1))});
    end
    req = 4'b1111;
    prev_done = 0;
    for (int k = 0; k < 5; k++) begin
      run_xfer(200, 1'b0, 1'b0);
      eg  = 4'(1 << order[k]);
      ecs = ~eg;
      vectors++; if (m_grant !== eg) begin miscompares++; $display("FAIL rr_grant[%0d]: got %b want %b", k, m_grant, eg); end
      vectors++; if (m_cs !== ecs) begin miscompares++; $display("FAIL rr_cs_n[%0d]: got %b want %b", k, m_cs, ecs); end
      if (sb.size() == 0) begin vectors++; miscompares++; $display("FAIL rr_sb[%0d]: got empty want entry", k); end
      else begin
        e = sb.pop_front();
        vectors++; if (m_done !== e.owner) begin miscompares++; $display("FAIL rr_done[%0d]: got %b want %b", k, m_done, e.owner); end
        vectors++; if (m_rx !== e.rx) begin miscompares++; $display("FAIL rr_rx[%0d]: got %h want %h", k, m_rx, e.rx); end
      end
      if (k > 0) begin
        vectors++; if (m_start - prev_done < 2) begin miscompares++; $display("FAIL rr_cs_gap[%0d]: got %0d want >=2", k, m_start - prev_done); end
      end
      vectors++; if (m_inv_bad != 0) begin miscompares++; $display("FAIL rr_onehot[%0d]: got %0d violations want 0", k, m_inv_bad); end
      prev_done = m_done_cyc;
    end
    req = '0;
    repeat (4) @(negedge pclk);
    vectors++; if (grant !== 4'h0 || busy !== 1'b0) begin miscompares++; $display("FAIL rr_quiet: got grant %b busy %b want 0000 0", grant, busy); end
  endtask

  task automatic test_delays();
    exp_t e;
    cfg_c2t_delay = 8'd3; cfg_t2c_delay = 8'd5; cfg_baud_div = 8'd0;
    req_tx_data[15:8] = 8'h96;
    sb.push_back('{owner: 4'b0010, rx: 8'h96});
    req = 4'b0010;
    run_xfer(200, 1'b1, 1'b0);
    vectors++; if (m_first_edge - m_start != 4) begin miscompares++; $display("FAIL dly_c2t: got %0d want 4", m_first_edge - m_start); end
    vectors++; if (m_done_cyc - m_last_edge != 6) begin miscompares++; $display("FAIL dly_t2c: got %0d want 6", m_done_cyc - m_last_edge); end
    vectors++; if (m_min_gap != 1 || m_max_gap != 1) begin miscompares++; $display("FAIL dly_halfperiod: got %0d..%0d want 1", m_min_gap, m_max_gap); end
    if (sb.size() == 0) begin vectors++; miscompares++; $display("FAIL dly_sb: got empty want entry"); end
    else begin
      e = sb.pop_front();
      vectors++; if (m_rx !== e.rx || m_done !== e.owner) begin miscompares++; $display("FAIL dly_result: got %b/%h want %b/%h", m_done, m_rx, e.owner, e.rx); end
    end
    cfg_c2t_delay = '0; cfg_t2c_delay = '0;
  endtask

  task automatic test_reset_abort();
    exp_t e;
    int tog = 0;
    int ab_done = 0;
    logic p;
    cfg_baud_div = 8'd1;
    req_tx_data[23:16] = 8'h5A;
    sb.push_back('{owner: 4'b0100, rx: 8'h5A});
    req = 4'b0100;
    p = sclk;
    for (int i = 0; i < 200 && tog < 7; i++) begin
      @(negedge pclk);
      if (done != '0) ab_done++;
      if (busy && sclk != p) tog++;
      p = sclk;
    end
    vectors++; if (tog != 7) begin miscompares++; $display("FAIL ab_reach: got %0d edges want 7", tog); end
    #1 areset = 1'b0;
    #1;
    vectors++; if (cs_n !== 4'hF || sclk !== 1'b0 || grant !== 4'h0) begin miscompares++; $display("FAIL ab_async: got cs %b sclk %b grant %b want 1111 0 0000", cs_n, sclk, grant); end
    @(negedge pclk);
    if (done != '0) ab_done++;
    vectors++; if (ab_done != 0) begin miscompares++; $display("FAIL ab_no_done: got %0d pulses want 0", ab_done); end
    areset = 1'b1;
    run_xfer(200, 1'b1, 1'b0);
    vectors++; if (m_toggles != 16) begin miscompares++; $display("FAIL ab_toggles: got %0d want 16", m_toggles); end
    if (sb.size() == 0) begin vectors++; miscompares++; $display("FAIL ab_sb: got empty want entry"); end
    else begin
      e = sb.pop_front();
      vectors++; if (m_done !== e.owner) begin miscompares++; $display("FAIL ab_done: got %b want %b", m_done, e.owner); end
      vectors++; if (m_rx !== e.rx) begin miscompares++; $display("FAIL ab_rx: got %h want %h", m_rx, e.rx); end
    end
  endtask

  task automatic test_baud_change();
    exp_t e;
    cfg_baud_div = 8'd1;
    req_tx_data[31:24] = 8'hC3;
    sb.push_back('{owner: 4'b1000, rx: 8'hC3});
    req = 4'b1000;
    run_xfer(200, 1'b1, 1'b1);
    vectors++; if (m_min_gap != 2 || m_max_gap != 2) begin miscompares++; $display("FAIL bd_old_halfperiod: got %0d..%0d want 2", m_min_gap, m_max_gap); end
    if (sb.size() == 0) begin vectors++; miscompares++; $display("FAIL bd_sb: got empty want entry"); end
    else begin
      e = sb.pop_front();
      vectors++; if (m_rx !== e.rx || m_done !== e.owner) begin miscompares++; $display("FAIL bd_latched_tx: got %b/%h want %b/%h", m_done, m_rx, e.owner, e.rx); end
    end
    req_tx_data[7:0] = 8'h69;
    sb.push_back('{owner: 4'b0001, rx: 8'h69});
    req = 4'b0001;
    run_xfer(400, 1'b1, 1'b0);
    vectors++; if (m_min_gap != 8 || m_max_gap != 8) begin miscompares++; $display("FAIL bd_new_halfperiod: got %0d..%0d want 8", m_min_gap, m_max_gap); end
    if (sb.size() == 0) begin vectors++; miscompares++; $display("FAIL bd_sb2: got empty want entry"); end
    else begin
      e = sb.pop_front();
      vectors++; if (m_rx !== e.rx || m_done !== e.owner) begin miscompares++; $display("FAIL bd_second: got %b/%h want %b/%h", m_done, m_rx, e.owner, e.rx); end
    end
  endtask

  task automatic test_baud_max();
    exp_t e;
    cfg_baud_div = 8'hFF;
    req_tx_data[15:8] = 8'h0F;
    sb.push_back('{owner: 4'b0010, rx: 8'h0F});
    req = 4'b0010;
    run_xfer(5000, 1'b1, 1'b0);
    vectors++; if (m_min_gap != 256 || m_max_gap != 256) begin miscompares++; $display("FAIL bmax_halfperiod: got %0d..%0d want 256", m_min_gap, m_max_gap); end
    vectors++; if (m_toggles != 16) begin miscompares++; $display("FAIL bmax_toggles: got %0d want 16", m_toggles); end
    if (sb.size() == 0) begin vectors++; miscompares++; $display("FAIL bmax_sb: got empty want entry"); end
    else begin
      e = sb.pop_front();
      vectors++; if (m_rx !== e.rx || m_done !== e.owner) begin miscompares++; $display("FAIL bmax_result: got %b/%h want %b/%h", m_done, m_rx, e.owner, e.rx); end
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode3();
    test_round_robin();
    test_delays();
    test_reset_abort();
    test_baud_change();
    test_baud_max();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
